// File: rtl/if_stage_sram_pkg.sv
// Shared widths and state encoding for the instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_stage_sram_pkg;

  // {fs_pc[63:32], fs_inst[31:0]}
  localparam int FS_TO_DS_BUS_WD = 64;
  // {br_taken[32], br_target[31:0]}
  localparam int BR_BUS_WD       = 33;

  // S_REQ: presenting (or ready to present) a fetch request.
  // S_WAIT: one request accepted, waiting for its data.
  typedef enum logic {
    FS_STATE_REQ  = 1'b0,
    FS_STATE_WAIT = 1'b1
  } fs_state_e;

endpackage

// File: rtl/if_stage_sram.sv
// Instruction fetch: owns the PC, issues one SRAM-like read at a time, hands {pc, inst} to decode.
// Latency: req at t (addr_ok same cycle), data_ok at t+1, fs_to_ds_valid at t+2; one inst per 2 cycles.
// Backpressure: a request is issued only when the fs slot will be free, so data_ok never has to stall.
module if_stage_sram
  import if_stage_sram_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  // Architectural state of the stage.
  fs_state_e   r_state;
  logic [31:0] r_req_pc;    // address presented on the next request
  logic [31:0] r_cur_pc;    // address of the request in flight
  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic [31:0] r_fs_inst;
  logic        r_drop;      // in-flight response belongs to a squashed path

  // Next-state values.
  fs_state_e   w_state_nxt;
  logic [31:0] w_req_pc_nxt;
  logic [31:0] w_cur_pc_nxt;
  logic        w_fs_valid_nxt;
  logic [31:0] w_fs_pc_nxt;
  logic [31:0] w_fs_inst_nxt;
  logic        w_drop_nxt;

  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_fs_free;
  logic        w_req;
  logic        w_load;

  assign w_br_taken  = br_bus[32];
  assign w_br_target = br_bus[31:0];

  // Slot is free if empty now or being drained by decode this cycle.
  assign w_fs_free = ~r_fs_valid | ds_allowin;
  assign w_req     = (r_state == FS_STATE_REQ) & w_fs_free & ~reset;

  assign inst_sram_req   = w_req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_addr  = r_req_pc;
  assign inst_sram_wdata = 32'd0;

  // Reset forces the outputs low even before the registers settle.
  assign fs_to_ds_valid = r_fs_valid & ~reset;
  assign fs_to_ds_bus   = {r_fs_pc, r_fs_inst};

  // Next-state and datapath update; a taken branch overrides everything else.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_pc_nxt   = r_req_pc;
    w_cur_pc_nxt   = r_cur_pc;
    w_drop_nxt     = r_drop;
    w_fs_pc_nxt    = r_fs_pc;
    w_fs_inst_nxt  = r_fs_inst;
    w_load         = 1'b0;

    case (r_state)
      FS_STATE_REQ: begin
        if (w_req && inst_sram_addr_ok) begin
          w_state_nxt = FS_STATE_WAIT;
          if (w_br_taken) begin
            // Accepted address is already stale: fetch it, throw it away.
            w_drop_nxt   = 1'b1;
            w_req_pc_nxt = w_br_target;
          end else begin
            w_cur_pc_nxt = r_req_pc;
          end
        end else if (w_br_taken) begin
          // Not yet accepted, so just swap the address presented next cycle.
          w_req_pc_nxt = w_br_target;
        end
      end
      FS_STATE_WAIT: begin
        if (inst_sram_data_ok) begin
          w_state_nxt = FS_STATE_REQ;
          if (r_drop || w_br_taken) begin
            w_drop_nxt = 1'b0;
            if (w_br_taken) begin
              w_req_pc_nxt = w_br_target;
            end
          end else begin
            w_load        = 1'b1;
            w_fs_pc_nxt   = r_cur_pc;
            w_fs_inst_nxt = inst_sram_rdata;
            w_req_pc_nxt  = r_cur_pc + 32'd4;
          end
        end else if (w_br_taken) begin
          w_drop_nxt   = 1'b1;
          w_req_pc_nxt = w_br_target;
        end
      end
      default: begin
        w_state_nxt = FS_STATE_REQ;
      end
    endcase

    // fs slot: drained by decode, refilled by a good response, flushed by a branch.
    w_fs_valid_nxt = r_fs_valid & ~ds_allowin;
    if (w_load) begin
      w_fs_valid_nxt = 1'b1;
    end
    if (w_br_taken) begin
      w_fs_valid_nxt = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FS_STATE_REQ;
      r_req_pc   <= RESET_PC;
      r_cur_pc   <= RESET_PC;
      r_fs_valid <= 1'b0;
      r_fs_pc    <= 32'd0;
      r_fs_inst  <= 32'd0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_cur_pc   <= w_cur_pc_nxt;
      r_fs_valid <= w_fs_valid_nxt;
      r_fs_pc    <= w_fs_pc_nxt;
      r_fs_inst  <= w_fs_inst_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage_sram.sv
// Directed per-cycle vectors for the fetch stage; the bench acts as the instruction slave.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: ds_allowin is driven directly from the vectors.
module tb_if_stage_sram;
  import if_stage_sram_pkg::*;

  logic                       clk;
  logic                       reset;
  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_req;
  logic                       inst_sram_wr;
  logic [1:0]                 inst_sram_size;
  logic [3:0]                 inst_sram_wstrb;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic                       inst_sram_addr_ok;
  logic                       inst_sram_data_ok;
  logic [31:0]                inst_sram_rdata;

  if_stage_sram #(.RESET_PC(32'h1c00_0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        alw;
    logic        bt;
    logic [31:0] tgt;
    logic        aok;
    logic        dok;
    logic [31:0] rdat;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, input logic alw, input logic bt, input logic [31:0] tgt,
                     input logic aok, input logic dok, input logic [31:0] rdat,
                     input logic ereq, input logic [31:0] eaddr, input logic evld,
                     input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v.rst = rst; v.alw = alw; v.bt = bt; v.tgt = tgt; v.aok = aok; v.dok = dok; v.rdat = rdat;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc; v.einst = einst;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic alw, input logic bt, input logic [31:0] tgt,
                       input logic aok, input logic dok, input logic [31:0] rdat);
    reset             = rst;
    ds_allowin        = alw;
    br_bus            = {bt, tgt};
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok;
    inst_sram_rdata   = rdat;
  endtask

  initial begin
    logic [63:0] held;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);

    //  rst alw bt  tgt           aok dok rdat          req addr          vld pc            inst
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h1c000000, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h1c000000, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         0, 1, 32'h11111111,  0, 32'h1c000000, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h1c000004, 1, 32'h1c000000, 32'h11111111);
    add(0, 1, 0, 32'h0,         0, 1, 32'h22222222,  0, 32'h1c000004, 0, 32'h0,        32'h0);
    // branch coincident with addr_ok for 1c000008
    add(0, 1, 1, 32'h1c000100,  1, 0, 32'h0,         1, 32'h1c000008, 1, 32'h1c000004, 32'h22222222);
    add(0, 1, 0, 32'h0,         0, 1, 32'h0badc0de,  0, 32'h1c000100, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h1c000100, 0, 32'h0,        32'h0);
    // branch while waiting, data arrives a cycle later
    add(0, 1, 1, 32'h1c000200,  0, 0, 32'h0,         0, 32'h1c000100, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         0, 1, 32'hdeadbeef,  0, 32'h1c000200, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h1c000200, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         0, 1, 32'h55555555,  0, 32'h1c000200, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h1c000204, 1, 32'h1c000200, 32'h55555555);
    // branch coincident with data_ok
    add(0, 1, 1, 32'h1c000300,  0, 1, 32'h66666666,  0, 32'h1c000204, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h1c000300, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         0, 1, 32'h77777777,  0, 32'h1c000300, 0, 32'h0,        32'h0);
    // held by decode, then flushed by a branch to the top of the address space
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h1c000304, 1, 32'h1c000300, 32'h77777777);
    add(0, 0, 1, 32'hfffffffc,  0, 0, 32'h0,         0, 32'h1c000304, 1, 32'h1c000300, 32'h77777777);
    // addr_ok delayed three cycles, address held constant
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hfffffffc, 0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hfffffffc, 0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hfffffffc, 0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hfffffffc, 0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h88888888,  0, 32'hfffffffc, 0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h00000000, 1, 32'hfffffffc, 32'h88888888);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h00000000, 1, 32'hfffffffc, 32'h88888888);
    // reset while waiting; a stray data_ok afterwards must be ignored
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h00000000, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         0, 1, 32'h99999999,  1, 32'h1c000000, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h1c000000, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,         0, 1, 32'haaaaaaaa,  0, 32'h1c000000, 0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h1c000004, 1, 32'h1c000000, 32'haaaaaaaa);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].alw, vq[i].bt, vq[i].tgt, vq[i].aok, vq[i].dok, vq[i].rdat);
      #1;
      check($sformatf("v%0d req", i), {63'd0, inst_sram_req}, {63'd0, vq[i].ereq});
      check($sformatf("v%0d addr", i), {32'd0, inst_sram_addr}, {32'd0, vq[i].eaddr});
      check($sformatf("v%0d valid", i), {63'd0, fs_to_ds_valid}, {63'd0, vq[i].evld});
      if (vq[i].evld) begin
        check($sformatf("v%0d bus", i), fs_to_ds_bus, {vq[i].epc, vq[i].einst});
      end
    end

    // Decode stalls for five cycles: no request, bus frozen.
    held = {32'h1c000000, 32'haaaaaaaa};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      #1;
      check($sformatf("stall%0d req", k), {63'd0, inst_sram_req}, 64'd0);
      check($sformatf("stall%0d bus", k), fs_to_ds_bus, held);
    end
    // Releasing decode lets the request out in that same cycle.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
    check("release req", {63'd0, inst_sram_req}, 64'd1);
    check("release addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c000004});

    // Write side of the port is constant.
    check("tied", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
          {1'b0, 2'd2, 4'd0, 32'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
